// File: rtl/store_buffer.sv
// store_buffer
//   Store buffer between the execute-stage memory unit and the data cache.
//   Speculative stores are allocated at the tail, marked committed on ROB
//   retire (commit) requests, drained in order to memory over a valid/ready
//   handshake, and forwarded to younger loads with byte-strobe checking.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wreq_*            WPORTS store-allocate ports (index 0 oldest), wreq_ready
//                     when at least WPORTS entries are free
//   creq_valid        CPORTS commit requests; leading ones commit oldest
//                     uncommitted entries
//   flush             discard every uncommitted entry
//   rreq_* / rresp_*  RPORTS combinational load-forward lookups
//   mem_*             head entry drain handshake
//   empty, full       occupancy flags
module store_buffer #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned WPORTS = 1,
   parameter int unsigned CPORTS = 1,
   parameter int unsigned RPORTS = 1,
   parameter int unsigned XLEN   = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [WPORTS-1:0]              wreq_valid,
   input  logic [WPORTS-1:0][XLEN-1:0]    wreq_addr,
   input  logic [WPORTS-1:0][XLEN-1:0]    wreq_data,
   input  logic [WPORTS-1:0][XLEN/8-1:0]  wreq_strb,
   output logic                           wreq_ready,
   input  logic [CPORTS-1:0]              creq_valid,
   input  logic                           flush,
   input  logic [RPORTS-1:0]              rreq_valid,
   input  logic [RPORTS-1:0][XLEN-1:0]    rreq_addr,
   input  logic [RPORTS-1:0][XLEN/8-1:0]  rreq_strb,
   output logic [RPORTS-1:0]              rresp_hit,
   output logic [RPORTS-1:0]              rresp_conflict,
   output logic [RPORTS-1:0][XLEN-1:0]    rresp_data,
   output logic                           mem_valid,
   input  logic                           mem_ready,
   output logic [XLEN-1:0]                mem_addr,
   output logic [XLEN-1:0]                mem_data,
   output logic [XLEN/8-1:0]              mem_strb,
   output logic                           empty,
   output logic                           full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned SW = XLEN / 8;
   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0] WPORTS_P = PW'(WPORTS);

   // Pointers carry a wrap bit in the MSB so full and empty are distinct.
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] cmt_q,  cmt_d;
   logic [PW-1:0] tail_q, tail_d;

   logic [DEPTH-1:0][XLEN-1:0] ent_addr_q, ent_addr_d;
   logic [DEPTH-1:0][XLEN-1:0] ent_data_q, ent_data_d;
   logic [DEPTH-1:0][SW-1:0]   ent_strb_q, ent_strb_d;

   logic [PW-1:0] count;
   logic [PW-1:0] free_cnt;
   logic [PW-1:0] uncmt;
   logic [PW-1:0] alloc_cnt;
   logic [AW-1:0] alloc_idx;
   logic [AW-1:0] head_idx;
   logic          do_alloc;
   logic          do_pop;
   logic          lead_run;
   int unsigned   creq_lead;
   int unsigned   commit_n;

   logic          fwd_found;
   logic          fwd_ovl;
   logic [AW-1:0] fwd_idx;
   logic [SW-1:0] fwd_strb;
   logic [XLEN-1:0] fwd_data;

   logic          unused_addr_lsbs;

   // ------------------------------------------------------------------
   // Occupancy and handshake flags (registered pointers only)
   // ------------------------------------------------------------------
   always_comb begin
      count      = tail_q - head_q;
      free_cnt   = DEPTH_P - count;
      uncmt      = tail_q - cmt_q;
      wreq_ready = (free_cnt >= WPORTS_P);
      empty      = (count == '0);
      full       = (count == DEPTH_P);
      mem_valid  = (head_q != cmt_q);
      head_idx   = head_q[AW-1:0];
      do_pop     = mem_valid & mem_ready;
      mem_addr   = mem_valid ? ent_addr_q[head_idx] : '0;
      mem_data   = mem_valid ? ent_data_q[head_idx] : '0;
      mem_strb   = mem_valid ? ent_strb_q[head_idx] : '0;
   end

   // ------------------------------------------------------------------
   // Commit: count leading ones, clamp to the uncommitted population
   // ------------------------------------------------------------------
   always_comb begin
      creq_lead = 0;
      lead_run  = 1'b1;
      for (int unsigned c = 0; c < CPORTS; c++) begin
         if (lead_run && creq_valid[c]) begin
            creq_lead = creq_lead + 1;
         end else begin
            lead_run = 1'b0;
         end
      end
      commit_n = (creq_lead < 32'(uncmt)) ? creq_lead : 32'(uncmt);
      cmt_d    = cmt_q + PW'(commit_n);
   end

   // ------------------------------------------------------------------
   // Allocate: valid ports are compacted into consecutive tail slots
   // ------------------------------------------------------------------
   always_comb begin
      do_alloc   = wreq_ready & ~flush;
      alloc_cnt  = '0;
      alloc_idx  = '0;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      ent_strb_d = ent_strb_q;
      for (int unsigned p = 0; p < WPORTS; p++) begin
         if (do_alloc && wreq_valid[p]) begin
            alloc_idx             = tail_q[AW-1:0] + alloc_cnt[AW-1:0];
            ent_addr_d[alloc_idx] = wreq_addr[p];
            ent_data_d[alloc_idx] = wreq_data[p];
            ent_strb_d[alloc_idx] = wreq_strb[p];
            alloc_cnt             = alloc_cnt + 1'b1;
         end
      end
   end

   // Flush truncates to the post-commit cmt, so a same-cycle commit survives.
   always_comb begin
      head_d = head_q + PW'(do_pop);
      tail_d = flush ? cmt_d : (tail_q + alloc_cnt);
   end

   // ------------------------------------------------------------------
   // Load forwarding over [head, tail); the youngest dword match decides
   // ------------------------------------------------------------------
   always_comb begin
      rresp_hit      = '0;
      rresp_conflict = '0;
      rresp_data     = '0;
      fwd_found      = 1'b0;
      fwd_ovl        = 1'b0;
      fwd_idx        = '0;
      fwd_strb       = '0;
      fwd_data       = '0;
      for (int unsigned p = 0; p < RPORTS; p++) begin
         fwd_found = 1'b0;
         fwd_ovl   = 1'b0;
         fwd_strb  = '0;
         fwd_data  = '0;
         // Oldest to youngest: the last match written wins.
         for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q[AW-1:0] + AW'(k);
            if ((PW'(k) < count) &&
                (ent_addr_q[fwd_idx][XLEN-1:3] == rreq_addr[p][XLEN-1:3])) begin
               fwd_found = 1'b1;
               fwd_strb  = ent_strb_q[fwd_idx];
               fwd_data  = ent_data_q[fwd_idx];
               if ((ent_strb_q[fwd_idx] & rreq_strb[p]) != '0) begin
                  fwd_ovl = 1'b1;
               end
            end
         end
         if (rreq_valid[p] && fwd_found) begin
            if ((fwd_strb & rreq_strb[p]) == rreq_strb[p]) begin
               rresp_hit[p]  = 1'b1;
               rresp_data[p] = fwd_data;
            end else if (fwd_ovl) begin
               rresp_conflict[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      unused_addr_lsbs = 1'b0;
      for (int unsigned p = 0; p < RPORTS; p++) begin
         unused_addr_lsbs = unused_addr_lsbs ^ (^rreq_addr[p][2:0]);
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         cmt_q  <= cmt_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      ent_strb_q <= ent_strb_d;
   end

   // Commit requests beyond the uncommitted population are a protocol error.
   a_commit_excess: assert property (@(posedge clk) disable iff (reset)
      creq_lead <= 32'(uncmt));

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned WP    = 2;
   localparam int unsigned CP    = 2;
   localparam int unsigned RP    = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [WP-1:0]        wreq_valid;
   logic [WP-1:0][63:0]  wreq_addr;
   logic [WP-1:0][63:0]  wreq_data;
   logic [WP-1:0][7:0]   wreq_strb;
   logic                 wreq_ready;
   logic [CP-1:0]        creq_valid;
   logic                 flush;
   logic [RP-1:0]        rreq_valid;
   logic [RP-1:0][63:0]  rreq_addr;
   logic [RP-1:0][7:0]   rreq_strb;
   logic [RP-1:0]        rresp_hit;
   logic [RP-1:0]        rresp_conflict;
   logic [RP-1:0][63:0]  rresp_data;
   logic                 mem_valid;
   logic                 mem_ready;
   logic [63:0]          mem_addr;
   logic [63:0]          mem_data;
   logic [7:0]           mem_strb;
   logic                 empty;
   logic                 full;

   store_buffer #(
      .DEPTH (DEPTH),
      .WPORTS(WP),
      .CPORTS(CP),
      .RPORTS(RP),
      .XLEN  (64)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wreq_valid    (wreq_valid),
      .wreq_addr     (wreq_addr),
      .wreq_data     (wreq_data),
      .wreq_strb     (wreq_strb),
      .wreq_ready    (wreq_ready),
      .creq_valid    (creq_valid),
      .flush         (flush),
      .rreq_valid    (rreq_valid),
      .rreq_addr     (rreq_addr),
      .rreq_strb     (rreq_strb),
      .rresp_hit     (rresp_hit),
      .rresp_conflict(rresp_conflict),
      .rresp_data    (rresp_data),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .mem_strb      (mem_strb),
      .empty         (empty),
      .full          (full)
   );

   always #5 clk = ~clk;

   // Reference: a queue of stores in program order; the first ncmt are committed.
   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } ent_t;

   ent_t mq[$];
   int   ncmt;
   int   n_cmp;
   int   n_bad;

   typedef struct {
      logic        wv;
      logic [63:0] wa;
      logic [63:0] wd;
      logic [7:0]  ws;
      logic [1:0]  cv;
      logic        fl;
      logic        rv;
      logic [63:0] ra;
      logic [7:0]  rs;
      logic        mr;
      logic        e_rdy;
      logic        e_empty;
      logic        e_full;
      logic        e_mv;
      logic [63:0] e_maddr;
      logic        e_hit;
      logic        e_conf;
      logic [63:0] e_rdata;
   } vec_t;

   vec_t tbl[11];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      wreq_valid = '0;
      wreq_addr  = '0;
      wreq_data  = '0;
      wreq_strb  = '0;
      creq_valid = '0;
      flush      = 1'b0;
      rreq_valid = '0;
      rreq_addr  = '0;
      rreq_strb  = '0;
      mem_ready  = 1'b0;
   endtask

   task automatic check_model();
      int          sz;
      logic        mv;
      int          y;
      logic        ovl;
      logic        e_hit;
      logic        e_conf;
      logic [63:0] e_data;
      sz = mq.size();
      mv = (ncmt > 0);
      chk1("ready", wreq_ready, (DEPTH - sz) >= WP);
      chk1("empty", empty, sz == 0);
      chk1("full", full, sz == DEPTH);
      chk1("mem_valid", mem_valid, mv);
      chk64("mem_addr", mem_addr, mv ? mq[0].addr : 64'h0);
      chk64("mem_data", mem_data, mv ? mq[0].data : 64'h0);
      chk64("mem_strb", 64'(mem_strb), mv ? 64'(mq[0].strb) : 64'h0);
      for (int p = 0; p < RP; p++) begin
         e_hit  = 1'b0;
         e_conf = 1'b0;
         e_data = '0;
         y      = -1;
         ovl    = 1'b0;
         for (int i = sz - 1; i >= 0; i--) begin
            if ((mq[i].addr >> 3) == (rreq_addr[p] >> 3)) begin
               if (y < 0) y = i;
               if ((mq[i].strb & rreq_strb[p]) != 8'h0) ovl = 1'b1;
            end
         end
         if (rreq_valid[p] && y >= 0) begin
            if ((mq[y].strb & rreq_strb[p]) == rreq_strb[p]) begin
               e_hit  = 1'b1;
               e_data = mq[y].data;
            end else begin
               e_conf = ovl;
            end
         end
         chk1($sformatf("hit%0d", p), rresp_hit[p], e_hit);
         chk1($sformatf("conflict%0d", p), rresp_conflict[p], e_conf);
         chk64($sformatf("rdata%0d", p), rresp_data[p], e_data);
      end
   endtask

   task automatic update_model();
      int   sz;
      int   lead;
      int   c;
      logic pop;
      ent_t e;
      if (reset) begin
         mq.delete();
         ncmt = 0;
         return;
      end
      sz   = mq.size();
      lead = 0;
      if (creq_valid[0]) lead = creq_valid[1] ? 2 : 1;
      c    = (lead < sz - ncmt) ? lead : sz - ncmt;
      pop  = (ncmt > 0) && mem_ready;
      if (pop) begin
         void'(mq.pop_front());
         ncmt--;
      end
      ncmt += c;
      if (flush) begin
         while (mq.size() > ncmt) void'(mq.pop_back());
      end else if ((DEPTH - sz) >= WP) begin
         for (int p = 0; p < WP; p++) begin
            if (wreq_valid[p]) begin
               e.addr = wreq_addr[p];
               e.data = wreq_data[p];
               e.strb = wreq_strb[p];
               mq.push_back(e);
            end
         end
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      #1;
      if (!reset) check_model();
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ncmt  = 0;

      //        wv   wa          wd                      ws     cv     fl    rv    ra          rs     mr    rdy   emp   full  mv    maddr       hit   conf  rdata
      tbl[0]  = '{1'b1, 64'h1000, 64'h1122334455667788, 8'hFF, 2'b00, 1'b0, 1'b0, 64'h0,    8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0};
      tbl[1]  = '{1'b1, 64'h1000, 64'hAAAABBBB,         8'h0F, 2'b00, 1'b0, 1'b0, 64'h0,    8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0};
      tbl[2]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b1, 64'h1004, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b1, 64'h0};
      tbl[3]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b1, 64'h1000, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 64'hAAAABBBB};
      tbl[4]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b1, 64'h1000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b1, 64'h0};
      tbl[5]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b1, 64'h1008, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0};
      tbl[6]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b01, 1'b0, 1'b1, 64'h1000, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 64'hAAAABBBB};
      tbl[7]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b01, 1'b0, 1'b0, 64'h0,    8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0};
      tbl[8]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b0, 64'h0,    8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0};
      tbl[9]  = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b1, 64'h1004, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0};
      tbl[10] = '{1'b0, 64'h0,    64'h0,                8'h00, 2'b00, 1'b0, 1'b0, 64'h0,    8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0};

      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset values
      #1;
      chk1("rst_ready", wreq_ready, 1'b1);
      chk1("rst_mem_valid", mem_valid, 1'b0);
      chk1("rst_empty", empty, 1'b1);
      chk1("rst_full", full, 1'b0);
      chk64("rst_mem_addr", mem_addr, 64'h0);
      tick();

      // Directed vector table: forwarding, conflict, commit/drain latency
      for (int i = 0; i < 11; i++) begin
         idle();
         wreq_valid[0] = tbl[i].wv;
         wreq_addr[0]  = tbl[i].wa;
         wreq_data[0]  = tbl[i].wd;
         wreq_strb[0]  = tbl[i].ws;
         creq_valid    = tbl[i].cv;
         flush         = tbl[i].fl;
         rreq_valid[0] = tbl[i].rv;
         rreq_addr[0]  = tbl[i].ra;
         rreq_strb[0]  = tbl[i].rs;
         mem_ready     = tbl[i].mr;
         #1;
         chk1($sformatf("t%0d_ready", i), wreq_ready, tbl[i].e_rdy);
         chk1($sformatf("t%0d_empty", i), empty, tbl[i].e_empty);
         chk1($sformatf("t%0d_full", i), full, tbl[i].e_full);
         chk1($sformatf("t%0d_mvalid", i), mem_valid, tbl[i].e_mv);
         chk64($sformatf("t%0d_maddr", i), mem_addr, tbl[i].e_maddr);
         chk1($sformatf("t%0d_hit", i), rresp_hit[0], tbl[i].e_hit);
         chk1($sformatf("t%0d_conf", i), rresp_conflict[0], tbl[i].e_conf);
         chk64($sformatf("t%0d_rdata", i), rresp_data[0], tbl[i].e_rdata);
         tick();
      end

      // Fill with 4 pairs, commit all, drain 8 in order
      for (int k = 0; k < 4; k++) begin
         idle();
         wreq_valid = 2'b11;
         for (int p = 0; p < 2; p++) begin
            wreq_addr[p] = 64'h2000 + 64'(8 * (2 * k + p));
            wreq_data[p] = {$urandom, $urandom};
            wreq_strb[p] = 8'hFF;
         end
         tick();
      end
      #1;
      chk1("fill_full", full, 1'b1);
      chk1("fill_ready", wreq_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         idle();
         creq_valid = 2'b11;
         if (k == 0) begin
            wreq_valid = 2'b11;
            wreq_addr  = {64'h9008, 64'h9000};
         end
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         idle();
         mem_ready = 1'b1;
         #1;
         chk1($sformatf("drain%0d_valid", k), mem_valid, 1'b1);
         chk64($sformatf("drain%0d_addr", k), mem_addr, 64'h2000 + 64'(8 * k));
         tick();
      end
      idle();
      #1;
      chk1("drain_empty", empty, 1'b1);
      tick();

      // Allocate 5, commit 2, flush with a third commit and a dropped wreq
      for (int k = 0; k < 3; k++) begin
         idle();
         wreq_valid = (k == 2) ? 2'b01 : 2'b11;
         for (int p = 0; p < 2; p++) begin
            wreq_addr[p] = 64'h3000 + 64'(8 * (2 * k + p));
            wreq_data[p] = {$urandom, $urandom};
            wreq_strb[p] = 8'hFF;
         end
         tick();
      end
      idle();
      creq_valid = 2'b11;
      tick();
      idle();
      creq_valid = 2'b01;
      flush      = 1'b1;
      wreq_valid = 2'b11;
      wreq_addr  = {64'h4008, 64'h4000};
      tick();
      for (int k = 0; k < 3; k++) begin
         idle();
         mem_ready = 1'b1;
         #1;
         chk64($sformatf("flush_drain%0d", k), mem_addr, 64'h3000 + 64'(8 * k));
         tick();
      end
      idle();
      #1;
      chk1("flush_empty", empty, 1'b1);
      tick();

      // Back-pressure: held outputs for 5 cycles, then exactly one pop
      idle();
      wreq_valid = 2'b11;
      wreq_addr  = {64'h5008, 64'h5000};
      wreq_data  = {64'hCAFE0002, 64'hCAFE0001};
      wreq_strb  = {8'h0F, 8'hF0};
      tick();
      idle();
      creq_valid = 2'b11;
      tick();
      for (int k = 0; k < 5; k++) begin
         idle();
         #1;
         chk64($sformatf("stall%0d_addr", k), mem_addr, 64'h5000);
         chk64($sformatf("stall%0d_data", k), mem_data, 64'hCAFE0001);
         tick();
      end
      idle();
      mem_ready = 1'b1;
      tick();
      idle();
      #1;
      chk64("stall_one_pop", mem_addr, 64'h5008);
      tick();
      idle();
      mem_ready = 1'b1;
      tick();

      // Reset in the middle of a stalled drain
      idle();
      wreq_valid = 2'b11;
      wreq_addr  = {64'h6008, 64'h6000};
      wreq_strb  = 8'hFF;
      tick();
      idle();
      wreq_valid = 2'b01;
      wreq_addr  = {64'h0, 64'h6010};
      creq_valid = 2'b11;
      tick();
      idle();
      creq_valid = 2'b01;
      tick();
      idle();
      #1;
      chk1("prerst_valid", mem_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk1("postrst_valid", mem_valid, 1'b0);
      chk1("postrst_empty", empty, 1'b1);
      chk1("postrst_ready", wreq_ready, 1'b1);
      tick();

      // Randomized traffic against the reference queue
      for (int cyc = 0; cyc < 800; cyc++) begin
         int um;
         int n;
         idle();
         reset = ($urandom_range(0, 249) == 0);
         wreq_valid = 2'($urandom);
         for (int p = 0; p < 2; p++) begin
            wreq_addr[p] = 64'h6000 + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
            wreq_data[p] = {$urandom, $urandom};
            wreq_strb[p] = 8'($urandom);
            rreq_addr[p] = 64'h6000 + 64'(8 * $urandom_range(0, 4)) + 64'($urandom_range(0, 7));
            rreq_strb[p] = 8'($urandom);
         end
         rreq_valid = 2'($urandom);
         um = mq.size() - ncmt;
         n  = $urandom_range(0, (um < 2) ? um : 2);
         if (n == 2)      creq_valid = 2'b11;
         else if (n == 1) creq_valid = 2'b01;
         else             creq_valid = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
         flush     = ($urandom_range(0, 15) == 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
